// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the integer register file
//
// Purpose: default sizing, the hardwired-zero register index, and data/address
// typedefs for the default configuration.
// Ports: none (package).
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int ZERO_REG      = 0;

    typedef logic [XLEN_DEFAULT-1:0]           xlen_t;
    typedef logic [$clog2(NREGS_DEFAULT)-1:0]  regaddr_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// rtl/regfile_busy_tracker.sv - per-register pending-write scoreboard
//
// Purpose: holds one busy bit per architectural register. Issue sets a bit,
// writeback clears it; when both hit the same register in one cycle the issue
// wins, because it names a newer producer than the one being written back.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   set_valid, set_addr  issue of a destination register
//   clr_valid, clr_addr  writeback of a register
//   busy                 current busy vector (bit 0 always 0)
//   any_busy             OR of all busy bits
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_valid,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_valid,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic             any_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        // Clear first so a same-register set overrides it.
        if (clr_valid && (clr_addr != AW'(ZERO_REG))) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_valid && (set_addr != AW'(ZERO_REG))) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_scoreboard_module.sv
// rtl/regfile_scoreboard_module.sv - RV32 integer register file with busy scoreboard
//
// Purpose: NREAD combinational read ports, one synchronous write port, x0
// hardwired to zero, plus a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   rd_addr        packed read addresses, port i at [i*AW +: AW]
//   rd_data        packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy        busy bit of each addressed register
//   we, wr_addr, wr_data             writeback port
//   issue_valid, issue_rd            destination being issued
//   any_busy       OR of all busy bits
module regfile_scoreboard_module
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_hit;

    assign wr_hit = we && (wr_addr != AW'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
        end
        // Keeping x0 stored as zero lets the read mux skip an address compare.
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_busy_tracker #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_busy (
        .clk       (clk),
        .reset     (reset),
        .set_valid (issue_valid),
        .set_addr  (issue_rd),
        .clr_valid (we),
        .clr_addr  (wr_addr),
        .busy      (busy_vec),
        .any_busy  (any_busy)
    );

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[g*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = wr_hit && (addr == wr_addr);
        assign rd_data[g*XLEN +: XLEN] = fwd ? wr_data : regs_q[addr];
        // A same-cycle issue to the written register leaves it busy after the edge.
        assign rd_busy[g] = fwd ? (issue_valid && (issue_rd == wr_addr)) : busy_vec[addr];
`else
        assign rd_data[g*XLEN +: XLEN] = regs_q[addr];
        assign rd_busy[g]              = busy_vec[addr];
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard_module.sv
// tb/tb_regfile_scoreboard_module.sv - directed self-checking bench for regfile_scoreboard_module
module tb_regfile_scoreboard_module;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        any_busy;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard_module dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .any_busy    (any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] p1, input logic [4:0] p0);
        rd_addr = {p1, p0};
        #1;
    endtask

    initial begin
        reset = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        #12;
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk("reset_data", rd_data, 64'h0);
            chk("reset_busy", {62'h0, rd_busy}, 64'h0);
        end
        chk("reset_any_busy", {63'h0, any_busy}, 64'h0);

        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        rd(5'd5, 5'd5);
        chk("x5_both_ports", rd_data, 64'hDEADBEEF_DEADBEEF);

        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        tick();
        we = 1'b0;
        rd(5'd0, 5'd0);
        chk("x0_data", rd_data, 64'h0);

        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        rd(5'd7, 5'd7);
        chk("x7_busy", {62'h0, rd_busy}, 64'h3);
        chk("x7_any_busy", {63'h0, any_busy}, 64'h1);

        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        tick();
        we = 1'b0;
        rd(5'd7, 5'd7);
        chk("x7_cleared", {62'h0, rd_busy}, 64'h0);
        chk("x7_data", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("x7_any_clear", {63'h0, any_busy}, 64'h0);

        issue_valid = 1'b1; issue_rd = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        tick();
        issue_valid = 1'b0; we = 1'b0;
        rd(5'd9, 5'd9);
        chk("x9_data", rd_data, 64'h00000011_00000011);
        chk("x9_busy_wins", {62'h0, rd_busy}, 64'h3);

        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
        tick();
        we = 1'b0;
        rd(5'd9, 5'd9);
        chk("x9_second_write", {62'h0, rd_busy}, 64'h0);
        chk("x9_data2", rd_data, 64'h00000022_00000022);

        // issue and write to different registers in one cycle
        issue_valid = 1'b1; issue_rd = 5'd10; we = 1'b1; wr_addr = 5'd5; wr_data = 32'h33;
        tick();
        issue_valid = 1'b0; we = 1'b0;
        rd(5'd10, 5'd5);
        chk("diff_data", rd_data, 64'h00000000_00000033);
        chk("diff_busy", {62'h0, rd_busy}, 64'h2);

        // repeated issue does not count
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        tick();
        issue_valid = 1'b0;
        we = 1'b1; wr_addr = 5'd10; wr_data = 32'h44;
        tick();
        we = 1'b0;
        rd(5'd10, 5'd0);
        chk("repeat_issue_clear", {62'h0, rd_busy}, 64'h0);
        chk("repeat_any_busy", {63'h0, any_busy}, 64'h0);
        chk("x10_data", rd_data, 64'h00000044_00000000);

        // issue to x0 ignored
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        rd(5'd0, 5'd0);
        chk("x0_issue_any", {63'h0, any_busy}, 64'h0);

        // same-cycle write and read of x3, with a same-register issue
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
        issue_valid = 1'b1; issue_rd = 5'd3;
        rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
        chk("x3_same_cycle", rd_data, 64'hCAFEF00D_CAFEF00D);
        chk("x3_same_busy", {62'h0, rd_busy}, 64'h3);
`else
        chk("x3_same_cycle", rd_data, 64'h0);
        chk("x3_same_busy", {62'h0, rd_busy}, 64'h0);
`endif
        tick();
        we = 1'b0; issue_valid = 1'b0;
        rd(5'd3, 5'd3);
        chk("x3_next_cycle", rd_data, 64'hCAFEF00D_CAFEF00D);
        chk("x3_next_busy", {62'h0, rd_busy}, 64'h3);

        // asynchronous reset mid-operation
        issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; wr_addr = 5'd6; wr_data = 32'h55;
        tick();
        issue_valid = 1'b0; we = 1'b0;
        rd(5'd4, 5'd6);
        chk("pre_reset_x6", rd_data, 64'h00000000_00000055);
        chk("pre_reset_busy", {62'h0, rd_busy}, 64'h2);
        we = 1'b1; wr_addr = 5'd6; wr_data = 32'h77;
        issue_valid = 1'b1; issue_rd = 5'd6;
        reset = 1'b1;
        #1;
        chk("async_reset_data", rd_data, 64'h0);
        chk("async_reset_busy", {62'h0, rd_busy}, 64'h0);
        chk("async_reset_any", {63'h0, any_busy}, 64'h0);
        tick();
        @(negedge clk);
        reset = 1'b0; we = 1'b0; issue_valid = 1'b0;
        rd(5'd4, 5'd6);
        chk("post_reset_x6", rd_data, 64'h0);
        chk("post_reset_busy", {62'h0, rd_busy}, 64'h0);
        rd(5'd3, 5'd5);
        chk("post_reset_x3x5", rd_data, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
